// File: rtl/div_rate_ctrl.sv
// Programmable clock divider with a glitch-free registered output, a per-period tick,
// and a ready/valid divisor update that is deferred to the next period boundary while running.
module div_rate_ctrl #(
    parameter int CNT_W   = 16,
    parameter int DEF_DIV = 50000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             div_out,
    output logic             tick,
    output logic             busy
);

    localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_sh_q, div_sh_d;
    logic             cfg_err_q, cfg_err_d;
    logic             div_out_q, div_out_d;
    logic             accept, div_ok, boundary;

    assign accept   = cfg_valid && cfg_ready;
    assign div_ok   = (cfg_div >= CNT_W'(2));
    assign boundary = (cnt_q == div_act_q - ONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_act_q <= DEF_DIV_W;
            div_sh_q  <= '0;
            cfg_err_q <= 1'b0;
            div_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_act_q <= div_act_d;
            div_sh_q  <= div_sh_d;
            cfg_err_q <= cfg_err_d;
            div_out_q <= div_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_act_d = div_act_q;
        div_sh_d  = div_sh_q;
        cfg_err_d = accept && !div_ok;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (accept && div_ok) div_act_d = cfg_div;
                if (en)               state_d   = RUN;
            end
            RUN: begin
                cnt_d = boundary ? '0 : cnt_q + ONE;
                if (accept && div_ok) begin
                    // Stopping on this very boundary: nothing left to defer to, so load directly.
                    if (boundary && !en) begin
                        div_act_d = cfg_div;
                        state_d   = IDLE;
                    end else begin
                        div_sh_d = cfg_div;
                        state_d  = PEND;
                    end
                end else if (boundary && !en) begin
                    state_d = IDLE;
                end
            end
            PEND: begin
                cnt_d = boundary ? '0 : cnt_q + ONE;
                if (boundary) begin
                    div_act_d = div_sh_q;
                    state_d   = en ? RUN : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Registered from next-state values so div_out lines up with cnt without a comb path.
        div_out_d = (state_d != IDLE) && (cnt_d >= (div_act_d >> 1));
    end

    always_comb begin
        cfg_ready = (state_q != PEND);
        busy      = (state_q != IDLE);
        tick      = (state_q != IDLE) && boundary;
        cfg_err   = cfg_err_q;
        div_out   = div_out_q;
    end

endmodule

// File: doc/div_rate_ctrl.md
DIV_RATE_CTRL -- requirements
Module: div_rate_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning the counter and divisor width in bits.
REQ-002 SHALL have parameter DEF_DIV, default 50000, meaning the divisor loaded at reset.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state SHALL update on the posedge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: run request.
REQ-006 SHALL have port cfg_valid, input, 1 bit: new-divisor request.
REQ-007 SHALL have port cfg_div, input, CNT_W bits: requested divisor.
REQ-008 SHALL have port cfg_ready, output, 1 bit: the block can accept a divisor.
REQ-009 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when an accepted divisor is rejected.
REQ-010 SHALL have port div_out, output, 1 bit: the divided clock output.
REQ-011 SHALL have port tick, output, 1 bit: one-cycle pulse on the last cycle of each period.
REQ-012 SHALL have port busy, output, 1 bit: high while the divider is running.

Function
REQ-013 SHALL hold internal state: FSM {IDLE, RUN, PEND}, counter cnt, active divisor div_act, shadow divisor div_sh.
REQ-014 SHALL complete a config handshake on a cycle with cfg_valid=1 and cfg_ready=1; cfg_ready=1 in IDLE and RUN, 0 in PEND.
REQ-015 SHALL treat cfg_div<2 as invalid: the handshake completes, cfg_err=1 the next cycle, and state, div_act and div_sh are unchanged.
REQ-016 IDLE: cnt=0, div_out=0, tick=0, busy=0; a valid accept loads div_act directly, effective next cycle.
REQ-017 IDLE with en=1 SHALL go to RUN the next cycle with cnt=0; an accept and en in the same cycle SHALL start with the new divisor.
REQ-018 RUN and PEND: cnt SHALL increment by 1 each cycle and wrap from div_act-1 to 0; period = div_act cycles; busy=1.
REQ-019 SHALL drive div_out = (cnt >= floor(div_act/2)) in the same cycle, from a register with no combinational glitch (implementation computes next-state value); low time floor(D/2), high time D-floor(D/2).
REQ-020 SHALL assert tick=1 exactly on cycles where cnt==div_act-1 in RUN or PEND; otherwise 0.
REQ-021 RUN with a valid accept SHALL store cfg_div in div_sh and go to PEND.
REQ-022 PEND: on the boundary cycle (cnt==div_act-1), div_act<=div_sh and cnt wraps to 0, then go to RUN; a divisor never changes mid-period.
REQ-023 An accept on a RUN boundary cycle SHALL NOT affect the wrap in that cycle; it applies at the following boundary.
REQ-024 en=0 in RUN or PEND SHALL let the current period finish (tick included), apply any pending divisor, then go to IDLE.
REQ-025 en re-asserted before the boundary SHALL cancel the stop.
REQ-026 SHALL use unsigned arithmetic; cnt SHALL never exceed div_act-1; DEF_DIV<2 is illegal and need not be checked.

Reset
REQ-027 RST=1 on a posedge SHALL force IDLE, cnt=0, div_act=DEF_DIV, div_sh=0, div_out=0, tick=0, busy=0, cfg_err=0.
REQ-028 After reset, cfg_ready SHALL read 1, because the block is in IDLE.
REQ-029 RST SHALL override all other inputs, including in mid-period and in PEND; a pending divisor SHALL be discarded.

Verification (DEF_DIV=4, CNT_W=8)
REQ-030 Reset, then en=1: div_out repeats 0,0,1,1; tick high on cnt=3 every 4 cycles; busy=1.
REQ-031 While running div 4, cfg_div=6 accepted at cnt=1 -> cfg_ready=0, the current period still ends after 4 cycles, the next period is 0,0,0,1,1,1 with tick every 6 cycles, then cfg_ready=1.
REQ-032 cfg_div=1 accepted in RUN -> cfg_err pulse for one cycle; period stays 4; state stays RUN.
REQ-033 cfg_div=5 loaded in IDLE, then en=1 -> div_out 0,0,1,1,1 repeating; tick every 5 cycles.
REQ-034 en dropped at cnt=1 -> cnt reaches 3 with tick, then IDLE with busy=0 and div_out=0; en raised at cnt=2 instead -> no stop.
REQ-035 RST pulsed in PEND at cnt=2 (pending div 7) -> IDLE; after en=1 the period is 4; the pending 7 never appears.
